hdmi_period_sched: RTL
======================

# hdmi_period_sched

Sequences the HDMI TMDS channel period for every pixel clock: control, video preamble, video guard band, active video, and data-island preamble, guard bands and packet words. It sits between the video timing counters (x, y) and the TMDS channel muxes. It tells the muxes which period to drive and which CTL bits to encode. It also runs a handshake with an InfoFrame/audio packet source so that packets are placed into horizontal blanking.

## Interface
Parameters:
- FRAME_WIDTH, 800, total pixels per line
- FRAME_HEIGHT, 525, total lines per frame
- SCREEN_WIDTH, 640, active pixels per line
- SCREEN_HEIGHT, 480, active lines
- DI_START, 648, x at which a data-island preamble may begin
- MAX_PKTS, 2, maximum packets per data island (1..2)

Ports:
- pxl_clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-low
- x  in  10  current pixel column, 0..FRAME_WIDTH-1
- y  in  10  current line, 0..FRAME_HEIGHT-1
- pkt_valid  in  1  packet source has a 32-word packet ready
- pkt_done  out  1  one-cycle pulse on the last word of each packet sent
- period  out  3  period_t: CTRL, VID_PRE, VID_GB, VIDEO, DI_PRE, DI_GBL, DI_DATA, DI_GBT
- ctl  out  4  CTL[3:0] to encode on channels 1/2 during control periods
- di_word  out  5  word index within the current packet, 0..31

## Operation
Reset values (rst==0 at a clock edge): period=CTRL, ctl=0000, pkt_done=0, di_word=0, packet count=0. Reset mid-island aborts it and produces no pkt_done.

FSM states are the period_t values. A 5-bit counter times the preamble, guard and data phases.

Video-line mapping for the next line:
- next_active = (y==FRAME_HEIGHT-1) ? 1 : (y+1 < SCREEN_HEIGHT).
- VIDEO: x < SCREEN_WIDTH and y < SCREEN_HEIGHT.
- VID_PRE (ctl=0001): x in FRAME_WIDTH-10..FRAME_WIDTH-3, when next_active.
- VID_GB (ctl=0000): x in FRAME_WIDTH-2..FRAME_WIDTH-1, when next_active.

Data-island sequence, on any line:
- At x==DI_START, pkt_valid is sampled. If it is 1, the island is committed. If it is 0, the line stays CTRL.
- DI_PRE: 8 cycles, ctl=0101.
- DI_GBL: 2 cycles.
- DI_DATA: di_word counts 0..31 per packet.
- DI_GBT: 2 cycles, then CTRL.

Packet handshake:
- pkt_done is asserted while di_word==31.
- In that same cycle, if pkt_valid==1 and packets sent + 1 < MAX_PKTS, the next packet starts with di_word=0. Otherwise the block goes to DI_GBT.
- pkt_valid dropping inside a committed packet is ignored.
- The source clears or refreshes pkt_valid in the cycle after pkt_done.

Register rules:
- ctl=0000 in every period except VID_PRE and DI_PRE.
- di_word holds 0 outside DI_DATA.
- The packet count clears on entry to CTRL.

Elaboration-time check: DI_START + 12 + 32*MAX_PKTS + 12 ≤ FRAME_WIDTH-10, and DI_START ≥ SCREEN_WIDTH. Islands therefore never overlap video, its preamble, or the 12-cycle minimum control period.

## Timing
- All outputs are registered. The output in cycle t+1 reflects x, y and pkt_valid sampled in cycle t, so period==VIDEO aligns exactly with the registered data_enable in the pixel path.
- Latency: 1 cycle from x/y to period, ctl and di_word.
- pkt_done is coincident with the period==DI_DATA, di_word==31 output cycle.
- y wrap (524→0) schedules the line-0 video preamble on line 524. Line 479 schedules no preamble.

## Structure
- Package hdmi_pkg: period_t enum, CTL_VID_PRE=4'b0001, CTL_DI_PRE=4'b0101, PRE_LEN=8, GB_LEN=2, PKT_LEN=32, CTRL_MIN=12.
- Single FSM plus counters in one module, with no sub-module.

## Test plan
- **Reset:** hold rst=0 for 3 cycles during DI_DATA → period=CTRL, ctl=0000, di_word=0, no pkt_done; an island resumes only at the next DI_START.
- **Video line with pkt_valid=0, y=5, x swept 0..799** → outputs, one cycle late, are:
  - VIDEO for x 0..639;
  - CTRL for 640..789;
  - VID_PRE with ctl=0001 for 790..797;
  - VID_GB for 798..799.
- **Frame wrap:**
  - y=479 → no VID_PRE or VID_GB.
  - y=480..523 → period never VIDEO or VID_PRE.
  - y=524 → VID_PRE at x=790..797.
- **Single packet, pkt_valid=1 at x=648, cleared after pkt_done** →
  - DI_PRE with ctl=0101 for x 648..655;
  - DI_GBL for 656..657;
  - DI_DATA, di_word 0..31, for 658..689, with pkt_done at 689;
  - DI_GBT for 690..691, then CTRL.
- **Two packets with pkt_valid held high, MAX_PKTS=2** →
  - DI_DATA for 658..721;
  - pkt_done at 689 and 721;
  - DI_GBT for 722..723;
  - no third packet.
- **Reset at x=670 during DI_DATA** → CTRL on the next output, no pkt_done; the next line's island proceeds normally.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI TMDS period scheduler.
package hdmi_pkg;

    typedef enum logic [2:0] {
        CTRL    = 3'd0,
        VID_PRE = 3'd1,
        VID_GB  = 3'd2,
        VIDEO   = 3'd3,
        DI_PRE  = 3'd4,
        DI_GBL  = 3'd5,
        DI_DATA = 3'd6,
        DI_GBT  = 3'd7
    } period_t;

    localparam logic [3:0] CTL_VID_PRE = 4'b0001;
    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;
    localparam int         PRE_LEN     = 8;
    localparam int         GB_LEN      = 2;
    localparam int         PKT_LEN     = 32;
    localparam int         CTRL_MIN    = 12;

    // CTL bits are only non-zero during the two preamble periods.
    function automatic logic [3:0] ctl_for(input period_t p);
        logic [3:0] c;
        case (p)
            VID_PRE: c = CTL_VID_PRE;
            DI_PRE:  c = CTL_DI_PRE;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hdmi_period_sched.sv
// Per-pixel TMDS period sequencer: video timing decode plus data-island
// FSM with a packet-source handshake placing packets in horizontal blanking.
module hdmi_period_sched
    import hdmi_pkg::*;
#(
    parameter int FRAME_WIDTH   = 800,
    parameter int FRAME_HEIGHT  = 525,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int DI_START      = 648,
    parameter int MAX_PKTS      = 2
) (
    input  logic       pxl_clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       pkt_valid,
    output logic       pkt_done,
    output logic [2:0] period,
    output logic [3:0] ctl,
    output logic [4:0] di_word
);

    if ((DI_START + 2 * CTRL_MIN + PKT_LEN * MAX_PKTS > FRAME_WIDTH - 10) ||
        (DI_START < SCREEN_WIDTH) || (MAX_PKTS < 1) || (MAX_PKTS > 2)) begin : g_cfg_bad
        $error("hdmi_period_sched: data island does not fit in horizontal blanking");
    end

    localparam logic [9:0]  L_SW      = 10'(SCREEN_WIDTH);
    localparam logic [9:0]  L_SH      = 10'(SCREEN_HEIGHT);
    localparam logic [10:0] L_SH_W    = 11'(SCREEN_HEIGHT);
    localparam logic [9:0]  L_Y_LAST  = 10'(FRAME_HEIGHT - 1);
    localparam logic [9:0]  L_VP_LO   = 10'(FRAME_WIDTH - 10);
    localparam logic [9:0]  L_VP_HI   = 10'(FRAME_WIDTH - 3);
    localparam logic [9:0]  L_GB_LO   = 10'(FRAME_WIDTH - 2);
    localparam logic [9:0]  L_DI      = 10'(DI_START);
    localparam logic [4:0]  L_PRE_END = 5'(PRE_LEN - 1);
    localparam logic [4:0]  L_GB_END  = 5'(GB_LEN - 1);
    localparam logic [4:0]  L_PKT_END = 5'(PKT_LEN - 1);
    localparam logic [1:0]  L_MAXP    = 2'(MAX_PKTS);

    period_t     r_period;
    logic [4:0]  r_cnt;
    logic [1:0]  r_pkts;
    logic [3:0]  r_ctl;
    logic [4:0]  r_di_word;
    logic        r_pkt_done;

    logic [10:0] w_y_inc;
    logic        w_next_active;
    period_t     w_idle_period;
    period_t     w_next_period;
    logic [4:0]  w_next_cnt;
    logic [1:0]  w_next_pkts;

    // Period chosen from x/y alone while no data island is in flight.
    always_comb begin
        w_y_inc       = {1'b0, y} + 11'd1;
        w_next_active = (y == L_Y_LAST) ? 1'b1 : (w_y_inc < L_SH_W);
        w_idle_period = CTRL;
        if ((x < L_SW) && (y < L_SH)) begin
            w_idle_period = VIDEO;
        end else if ((x >= L_VP_LO) && (x <= L_VP_HI) && w_next_active) begin
            w_idle_period = VID_PRE;
        end else if ((x >= L_GB_LO) && w_next_active) begin
            w_idle_period = VID_GB;
        end else if ((x == L_DI) && pkt_valid) begin
            w_idle_period = DI_PRE;
        end else begin
            w_idle_period = CTRL;
        end
    end

    // Next-state and phase counter for the period FSM.
    always_comb begin
        w_next_period = r_period;
        w_next_cnt    = r_cnt;
        w_next_pkts   = r_pkts;
        case (r_period)
            DI_PRE: begin
                if (r_cnt == L_PRE_END) begin
                    w_next_period = DI_GBL;
                    w_next_cnt    = 5'd0;
                end else begin
                    w_next_cnt    = r_cnt + 5'd1;
                end
            end
            DI_GBL: begin
                if (r_cnt == L_GB_END) begin
                    w_next_period = DI_DATA;
                    w_next_cnt    = 5'd0;
                end else begin
                    w_next_cnt    = r_cnt + 5'd1;
                end
            end
            DI_DATA: begin
                // r_pkts counts packets completed before the one now ending.
                if (r_cnt == L_PKT_END) begin
                    w_next_cnt  = 5'd0;
                    w_next_pkts = r_pkts + 2'd1;
                    if (pkt_valid && ((r_pkts + 2'd1) < L_MAXP)) begin
                        w_next_period = DI_DATA;
                    end else begin
                        w_next_period = DI_GBT;
                    end
                end else begin
                    w_next_cnt = r_cnt + 5'd1;
                end
            end
            DI_GBT: begin
                if (r_cnt == L_GB_END) begin
                    w_next_period = w_idle_period;
                    w_next_cnt    = 5'd0;
                end else begin
                    w_next_cnt    = r_cnt + 5'd1;
                end
            end
            default: begin
                w_next_period = w_idle_period;
                w_next_cnt    = 5'd0;
            end
        endcase
        if (w_next_period == CTRL) begin
            w_next_pkts = 2'd0;
        end else begin
            w_next_pkts = w_next_pkts;
        end
    end

    // State and registered outputs.
    always_ff @(posedge pxl_clk) begin
        if (!rst) begin
            r_period   <= CTRL;
            r_cnt      <= 5'd0;
            r_pkts     <= 2'd0;
            r_ctl      <= 4'b0000;
            r_di_word  <= 5'd0;
            r_pkt_done <= 1'b0;
        end else begin
            r_period   <= w_next_period;
            r_cnt      <= w_next_cnt;
            r_pkts     <= w_next_pkts;
            r_ctl      <= ctl_for(w_next_period);
            r_di_word  <= (w_next_period == DI_DATA) ? w_next_cnt : 5'd0;
            r_pkt_done <= (w_next_period == DI_DATA) && (w_next_cnt == L_PKT_END);
        end
    end

    assign period   = r_period;
    assign ctl      = r_ctl;
    assign di_word  = r_di_word;
    assign pkt_done = r_pkt_done;

endmodule
